// File: rtl/accumulator_control_sequencer.sv
// Fetch/decode/execute controller for the 16-bit accumulator machine.
// Strobes are a combinational decode of the registered state; start/stop_req are level inputs.
module accumulator_control_sequencer #(
    parameter int         CNT_WIDTH = 16,
    parameter logic [3:0] ALU_ADD   = 4'b0000,
    parameter logic [3:0] ALU_SUB   = 4'b0001
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop_req,
    input  logic [3:0]           ir_opcode,
    input  logic [1:0]           ir_cond,
    input  logic                 acc_sign,
    input  logic                 acc_zero,
    output logic                 pc_write,
    output logic                 pc_sel,
    output logic                 mar_write,
    output logic                 mar_sel,
    output logic                 mbr_write,
    output logic                 mbr_sel,
    output logic                 ir_write,
    output logic                 acc_write,
    output logic [1:0]           acc_sel,
    output logic [3:0]           alu_op,
    output logic                 mem_write,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic                 retired,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F0     = 4'd1,
        S_F1     = 4'd2,
        S_F2     = 4'd3,
        S_F3     = 4'd4,
        S_DEC    = 4'd5,
        S_R0     = 4'd6,
        S_R1     = 4'd7,
        S_W0     = 4'd8,
        S_W1     = 4'd9,
        S_EXEC   = 4'd10,
        S_HALTED = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUBT  = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;
    localparam logic [3:0] OP_CLEAR = 4'hA;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   w_retire;
    logic                   w_skip;

    always_comb begin
        case (ir_cond)
            2'b00:   w_skip = acc_sign;
            2'b01:   w_skip = acc_zero;
            2'b10:   w_skip = !acc_sign && !acc_zero;
            default: w_skip = 1'b0;
        endcase
    end

    assign w_retire = (r_state == S_EXEC) || (r_state == S_W1) ||
                      ((r_state == S_DEC) && (ir_opcode == OP_HALT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALTED: if (start) w_next = S_F0;
            S_F0:             w_next = S_F1;
            S_F1:             w_next = S_F2;
            S_F2:             w_next = S_F3;
            S_F3:             w_next = S_DEC;
            S_DEC: begin
                case (ir_opcode)
                    OP_LOAD, OP_ADD, OP_SUBT:  w_next = S_R0;
                    OP_STORE:                  w_next = S_W0;
                    OP_JUMP, OP_SKIP, OP_CLEAR: w_next = S_EXEC;
                    OP_HALT:                   w_next = S_HALTED;
                    default:                   w_next = S_FAULT;
                endcase
            end
            S_R0:             w_next = S_R1;
            S_R1:             w_next = S_EXEC;
            S_W0:             w_next = S_W1;
            S_W1, S_EXEC:     w_next = stop_req ? S_IDLE : S_F0;
            S_FAULT:          w_next = S_FAULT;
            default:          w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        mar_write = 1'b0;
        mar_sel   = 1'b0;
        mbr_write = 1'b0;
        mbr_sel   = 1'b0;
        ir_write  = 1'b0;
        acc_write = 1'b0;
        acc_sel   = 2'd0;
        alu_op    = ALU_ADD;
        mem_write = 1'b0;
        case (r_state)
            S_F0:  mar_write = 1'b1;
            S_F2:  mbr_write = 1'b1;
            S_F3: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DEC: begin
                mar_write = 1'b1;
                mar_sel   = 1'b1;
            end
            S_R1:  mbr_write = 1'b1;
            S_W0: begin
                mbr_write = 1'b1;
                mbr_sel   = 1'b1;
            end
            S_W1:  mem_write = 1'b1;
            S_EXEC: begin
                case (ir_opcode)
                    OP_LOAD: begin
                        acc_write = 1'b1;
                        acc_sel   = 2'd1;
                    end
                    OP_ADD:  acc_write = 1'b1;
                    OP_SUBT: begin
                        acc_write = 1'b1;
                        alu_op    = ALU_SUB;
                    end
                    OP_CLEAR: begin
                        acc_write = 1'b1;
                        acc_sel   = 2'd2;
                    end
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                    end
                    // A taken skip is just one extra PC+1
                    OP_SKIP: pc_write = w_skip;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign busy        = !((r_state == S_IDLE) || (r_state == S_HALTED) || (r_state == S_FAULT));
    assign halted      = (r_state == S_HALTED);
    assign fault       = (r_state == S_FAULT);
    assign retired     = w_retire;
    assign instr_count = r_count;
    assign state       = r_state;

endmodule
